// File: rtl/instr_fetch.sv
// Byte-serial 6502 instruction fetch: reads opcode plus 0-2 operand bytes
// and hands {opcode, operand, pc, length} to the decoder over valid/ready.
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h8000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_req_o,
   output logic [15:0] mem_addr_o,
   input  logic        mem_valid_i,
   input  logic [7:0]  mem_rdata_i,
   output logic        instr_valid_o,
   input  logic        decode_ready_i,
   output logic [7:0]  opcode_o,
   output logic [15:0] data_o,
   output logic [15:0] instr_pc_o,
   output logic [1:0]  instr_len_o,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i
);

   typedef enum logic [2:0] {
      S_OP,
      S_OPD1,
      S_OPD2,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_pc;
   logic        r_req;
   logic [15:0] r_addr;
   logic [7:0]  r_op;
   logic [15:0] r_data;
   logic [15:0] r_ipc;
   logic [1:0]  r_len;
   logic        w_done;
   logic        w_req_next;
   logic [1:0]  w_len;
   logic [2:0]  w_a;
   logic [2:0]  w_b;
   logic [15:0] w_pc_inc;

   assign w_done   = r_req & mem_valid_i;
   assign w_pc_inc = r_pc + 16'd1;
   assign w_a      = mem_rdata_i[7:5];
   assign w_b      = mem_rdata_i[4:2];

   always_comb begin
      w_len = 2'd1;
      unique case (mem_rdata_i[1:0])
         2'b01: begin
            if (w_b == 3'b011 || w_b == 3'b110 || w_b == 3'b111)
               w_len = 2'd3;
            else
               w_len = 2'd2;
         end
         2'b10: begin
            unique case (w_b)
               3'b000, 3'b001, 3'b101: w_len = 2'd2;
               3'b011, 3'b111:         w_len = 2'd3;
               default:                w_len = 2'd1;
            endcase
         end
         2'b00: begin
            if (w_b == 3'b000) begin
               if (w_a == 3'b001)
                  w_len = 2'd3;
               else if (w_a[2])
                  w_len = 2'd2;
               else
                  w_len = 2'd1;
            end else begin
               unique case (w_b)
                  3'b001, 3'b100, 3'b101: w_len = 2'd2;
                  3'b011, 3'b111:         w_len = 2'd3;
                  default:                w_len = 2'd1;
               endcase
            end
         end
         default: w_len = 2'd1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_state <= S_OP;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_OP: begin
            if (w_done)
               w_next = (w_len != 2'd1) ? S_OPD1 : S_HOLD;
         end
         S_OPD1: begin
            if (w_done)
               w_next = (r_len == 2'd3) ? S_OPD2 : S_HOLD;
         end
         S_OPD2: begin
            if (w_done)
               w_next = S_HOLD;
         end
         S_HOLD: begin
            if (decode_ready_i)
               w_next = S_OP;
         end
         S_DRAIN: begin
            if (w_done)
               w_next = S_OP;
         end
         default: w_next = S_OP;
      endcase
      // An outstanding read must finish before the new pc is fetched
      if (redirect_i)
         w_next = (r_req && !mem_valid_i) ? S_DRAIN : S_OP;
   end

   // Request rises one cycle after entering a fetch state, holds until data
   assign w_req_next = !w_done
                    && (w_next != S_HOLD)
                    && (r_state != S_HOLD)
                    && !(redirect_i && (w_next != S_DRAIN));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc   <= RESET_PC;
         r_req  <= 1'b0;
         r_addr <= 16'h0000;
         r_op   <= 8'h00;
         r_data <= 16'h0000;
         r_ipc  <= 16'h0000;
         r_len  <= 2'd0;
      end else begin
         r_req <= w_req_next;
         if (w_req_next && !r_req)
            r_addr <= r_pc;
         if (redirect_i)
            r_pc <= redirect_pc_i;
         else if (w_done && r_state != S_DRAIN)
            r_pc <= w_pc_inc;
         if (w_done && !redirect_i) begin
            unique case (r_state)
               S_OP: begin
                  r_op   <= mem_rdata_i;
                  r_ipc  <= r_pc;
                  r_len  <= w_len;
                  r_data <= 16'h0000;
               end
               S_OPD1: r_data <= {mem_rdata_i, 8'h00};
               S_OPD2: r_data <= {mem_rdata_i, r_data[15:8]};
               default: ;
            endcase
         end
      end
   end

   assign mem_req_o     = r_req;
   assign mem_addr_o    = r_addr;
   assign instr_valid_o = (r_state == S_HOLD);
   assign opcode_o      = r_op;
   assign data_o        = r_data;
   assign instr_pc_o    = r_ipc;
   assign instr_len_o   = r_len;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: byte memory responder with latency, scoreboard
// queues for read addresses and delivered instructions.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic        mem_valid_i = 1'b0;
   logic [7:0]  mem_rdata_i = 8'h00;
   logic        instr_valid_o;
   logic        decode_ready_i = 1'b0;
   logic [7:0]  opcode_o;
   logic [15:0] data_o;
   logic [15:0] instr_pc_o;
   logic [1:0]  instr_len_o;
   logic        redirect_i = 1'b0;
   logic [15:0] redirect_pc_i = 16'h0000;

   instr_fetch #(.RESET_PC(16'h8000)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_valid_i    (mem_valid_i),
      .mem_rdata_i    (mem_rdata_i),
      .instr_valid_o  (instr_valid_o),
      .decode_ready_i (decode_ready_i),
      .opcode_o       (opcode_o),
      .data_o         (data_o),
      .instr_pc_o     (instr_pc_o),
      .instr_len_o    (instr_len_o),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [1:0]  len;
      logic [15:0] data;
   } vec_t;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] data;
      logic [15:0] pc;
      logic [1:0]  len;
   } exp_t;

   logic [7:0]  mem [0:65535];
   exp_t        exp_q[$];
   logic [15:0] addr_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat = 1;
   int          wcnt = 0;
   bit          spur = 1'b0;
   bit          rnd_rdy = 1'b0;
   logic        prev_req = 1'b0;
   logic        prev_done = 1'b0;
   logic [15:0] prev_addr = 16'h0000;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm, input string msg);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s", nm, msg);
   endtask

   // Called at a negedge: drive memory, check what the next posedge sees,
   // then advance to the following negedge.
   task automatic cycle();
      exp_t e;
      if (rnd_rdy)
         decode_ready_i = 1'($urandom_range(0, 1));
      if (mem_req_o) begin
         if (wcnt + 1 >= lat) begin
            mem_valid_i = 1'b1;
            mem_rdata_i = mem[mem_addr_o];
            wcnt = 0;
         end else begin
            mem_valid_i = 1'b0;
            mem_rdata_i = 8'h5A;
            wcnt++;
         end
      end else begin
         mem_valid_i = spur;
         mem_rdata_i = 8'hC3;
         wcnt = 0;
      end
      if (!rst_i) begin
         if (prev_req && !prev_done && mem_req_o)
            chk("addr_hold", 32'(mem_addr_o), 32'(prev_addr));
         if (mem_req_o && mem_valid_i) begin
            if (addr_q.size() == 0)
               fail("rd_extra", $sformatf("read at %h, none wanted", mem_addr_o));
            else
               chk("rd_addr", 32'(mem_addr_o), 32'(addr_q.pop_front()));
         end
         if (instr_valid_o && decode_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
               fail("xfer_extra", $sformatf("op %h pc %h, none wanted",
                    opcode_o, instr_pc_o));
            end else begin
               e = exp_q.pop_front();
               chk("xfer_op", 32'(opcode_o), 32'(e.op));
               chk("xfer_data", 32'(data_o), 32'(e.data));
               chk("xfer_pc", 32'(instr_pc_o), 32'(e.pc));
               chk("xfer_len", 32'(instr_len_o), 32'(e.len));
            end
         end
      end
      prev_req  = mem_req_o && !rst_i;
      prev_done = mem_req_o && mem_valid_i;
      prev_addr = mem_addr_o;
      @(negedge clk);
   endtask

   task automatic push_instr(input logic [15:0] pc, input logic [7:0] op,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input logic [1:0] len, input logic [15:0] data);
      exp_t        e;
      logic [15:0] a1;
      logic [15:0] a2;
      a1 = pc + 16'd1;
      a2 = pc + 16'd2;
      mem[pc] = op;
      addr_q.push_back(pc);
      if (len >= 2'd2) begin
         mem[a1] = b1;
         addr_q.push_back(a1);
      end
      if (len == 2'd3) begin
         mem[a2] = b2;
         addr_q.push_back(a2);
      end
      e.op   = op;
      e.data = data;
      e.pc   = pc;
      e.len  = len;
      exp_q.push_back(e);
   endtask

   task automatic run(input string nm, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      if (exp_q.size() > 0) begin
         fail(nm, $sformatf("timeout, %0d pending want 0", exp_q.size()));
         exp_q.delete();
      end
      chk({nm, "_rd_left"}, 32'(addr_q.size()), 32'd0);
      addr_q.delete();
   endtask

   task automatic wait_valid(input string nm, input int budget);
      int n;
      n = 0;
      while (!instr_valid_o && n < budget) begin
         cycle();
         n++;
      end
      if (!instr_valid_o)
         fail(nm, "timeout waiting for instr_valid_o");
   endtask

   task automatic wait_req(input string nm, input logic [15:0] a,
                           input int budget);
      int n;
      n = 0;
      while (!(mem_req_o && mem_addr_o == a) && n < budget) begin
         cycle();
         n++;
      end
      if (!(mem_req_o && mem_addr_o == a))
         fail(nm, $sformatf("timeout waiting for request at %h", a));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_req"},   32'(mem_req_o),     32'd0);
      chk({nm, "_addr"},  32'(mem_addr_o),    32'd0);
      chk({nm, "_valid"}, 32'(instr_valid_o), 32'd0);
      chk({nm, "_op"},    32'(opcode_o),      32'd0);
      chk({nm, "_data"},  32'(data_o),        32'd0);
      chk({nm, "_pc"},    32'(instr_pc_o),    32'd0);
      chk({nm, "_len"},   32'(instr_len_o),   32'd0);
   endtask

   function automatic vec_t mk(input logic [7:0] op, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [1:0] len,
                               input logic [15:0] data);
      vec_t v;
      v.op   = op;
      v.b1   = b1;
      v.b2   = b2;
      v.len  = len;
      v.data = data;
      return v;
   endfunction

   initial begin
      vec_t        tv [19];
      logic [15:0] tpc;
      logic [15:0] a1;

      tv[0]  = mk(8'h00, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[1]  = mk(8'h20, 8'h00, 8'h90, 2'd3, 16'h9000);
      tv[2]  = mk(8'h60, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[3]  = mk(8'hC0, 8'h05, 8'h00, 2'd2, 16'h0500);
      tv[4]  = mk(8'h0A, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[5]  = mk(8'h4C, 8'h34, 8'h12, 2'd3, 16'h1234);
      tv[6]  = mk(8'hB1, 8'h80, 8'h00, 2'd2, 16'h8000);
      tv[7]  = mk(8'hBD, 8'h00, 8'h02, 2'd3, 16'h0200);
      tv[8]  = mk(8'h8E, 8'h11, 8'h22, 2'd3, 16'h2211);
      tv[9]  = mk(8'h96, 8'h33, 8'h00, 2'd2, 16'h3300);
      tv[10] = mk(8'h03, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[11] = mk(8'h24, 8'h44, 8'h00, 2'd2, 16'h4400);
      tv[12] = mk(8'h08, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[13] = mk(8'h40, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[14] = mk(8'h2C, 8'h55, 8'h66, 2'd3, 16'h6655);
      tv[15] = mk(8'h18, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[16] = mk(8'h19, 8'h01, 8'h02, 2'd3, 16'h0201);
      tv[17] = mk(8'h5A, 8'h00, 8'h00, 2'd1, 16'h0000);
      tv[18] = mk(8'h06, 8'h77, 8'h00, 2'd2, 16'h7700);

      for (int i = 0; i < 65536; i++)
         mem[i] = 8'h00;

      // Reset state
      rst_i = 1'b1;
      @(negedge clk);
      cycle();
      cycle();
      chk_zero("reset");

      // Immediate, absolute, implied back to back from RESET_PC
      push_instr(16'h8000, 8'hA9, 8'h42, 8'h00, 2'd2, 16'h4200);
      push_instr(16'h8002, 8'hAD, 8'h34, 8'h12, 2'd3, 16'h1234);
      push_instr(16'h8005, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0000);
      rst_i = 1'b0;
      decode_ready_i = 1'b1;
      lat = 1;
      run("basic", 200);

      // Length table, slower memory, random ready, spurious valids
      tpc = 16'h8006;
      for (int i = 0; i < 19; i++) begin
         push_instr(tpc, tv[i].op, tv[i].b1, tv[i].b2, tv[i].len, tv[i].data);
         tpc = tpc + 16'(tv[i].len);
      end
      lat = 2;
      spur = 1'b1;
      rnd_rdy = 1'b1;
      run("table", 3000);
      rnd_rdy = 1'b0;
      spur = 1'b0;

      // Backpressure: outputs frozen, no requests
      decode_ready_i = 1'b0;
      lat = 1;
      push_instr(tpc, 8'hA5, 8'h10, 8'h00, 2'd2, 16'h1000);
      wait_valid("bp_wait", 50);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(instr_valid_o), 32'd1);
         chk("bp_req", 32'(mem_req_o), 32'd0);
         chk("bp_op", 32'(opcode_o), 32'h00A5);
         chk("bp_data", 32'(data_o), 32'h1000);
         chk("bp_pc", 32'(instr_pc_o), 32'(tpc));
         chk("bp_len", 32'(instr_len_o), 32'd2);
         cycle();
      end
      decode_ready_i = 1'b1;
      run("bp", 10);
      chk("bp_drop", 32'(instr_valid_o), 32'd0);
      tpc = tpc + 16'd2;

      // Redirect while the first operand read is outstanding
      lat = 3;
      a1 = tpc + 16'd1;
      mem[tpc] = 8'hA9;
      mem[a1] = 8'h77;
      addr_q.push_back(tpc);
      addr_q.push_back(a1);
      push_instr(16'hC000, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0000);
      wait_req("rd_wait", a1, 100);
      redirect_i = 1'b1;
      redirect_pc_i = 16'hC000;
      cycle();
      redirect_i = 1'b0;
      chk("drain_req", 32'(mem_req_o), 32'd1);
      chk("drain_addr", 32'(mem_addr_o), 32'(a1));
      chk("drain_valid", 32'(instr_valid_o), 32'd0);
      run("drain", 100);

      // Redirect in hold cancels the handshake; then a wrapping JMP
      lat = 1;
      mem[16'hC001] = 8'hA9;
      mem[16'hC002] = 8'h55;
      addr_q.push_back(16'hC001);
      addr_q.push_back(16'hC002);
      decode_ready_i = 1'b0;
      wait_valid("hc_wait", 50);
      chk("hc_op", 32'(opcode_o), 32'h00A9);
      chk("hc_pc", 32'(instr_pc_o), 32'hC001);
      push_instr(16'hFFFE, 8'h4C, 8'h00, 8'h90, 2'd3, 16'h9000);
      push_instr(16'h0001, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0000);
      redirect_i = 1'b1;
      redirect_pc_i = 16'hFFFE;
      decode_ready_i = 1'b1;
      cycle();
      redirect_i = 1'b0;
      chk("hc_cancel", 32'(instr_valid_o), 32'd0);
      run("wrap", 100);

      // Synchronous reset during the second operand read
      lat = 3;
      mem[16'h0002] = 8'hAD;
      mem[16'h0003] = 8'h11;
      mem[16'h0004] = 8'h22;
      addr_q.push_back(16'h0002);
      addr_q.push_back(16'h0003);
      wait_req("rst_wait", 16'h0004, 100);
      rst_i = 1'b1;
      cycle();
      chk_zero("midrst");
      chk("midrst_rd_left", 32'(addr_q.size()), 32'd0);
      rst_i = 1'b0;
      lat = 1;
      push_instr(16'h8000, 8'hA9, 8'h42, 8'h00, 2'd2, 16'h4200);
      run("rst_pc", 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
